// File: rtl/nes_pad_responder.sv
// nes_pad_responder: 4021-style NES pad responder; optional turbo A/B under NES_PAD_TURBO_EN
module nes_pad_responder #(
    parameter int TURBO_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       turbo_a,
    input  logic       turbo_b,
    input  logic       nes_latch,
    input  logic       nes_pulse,
    output logic       nes_data,
    output logic [3:0] bit_count,
    output logic       frame_done,
    output logic [7:0] poll_count
);
    logic       l_meta, l_sync, l_prev;
    logic       p_meta, p_sync, p_prev;
    logic       l_rise, p_rise;
    logic [7:0] shift;
    logic [7:0] eb;

    // bring latch and pulse into the clk domain and keep one cycle of history for edge detection
    always_ff @(posedge clk or negedge reset)
        if (!reset) {l_meta, l_sync, l_prev, p_meta, p_sync, p_prev} <= '0;
        else begin
            {l_meta, l_sync, l_prev} <= {nes_latch, l_meta, l_sync};
            {p_meta, p_sync, p_prev} <= {nes_pulse, p_meta, p_sync};
        end

    assign l_rise = l_sync & ~l_prev;
    assign p_rise = p_sync & ~p_prev;

`ifdef NES_PAD_TURBO_EN
    logic [7:0] turbo_cnt;
    logic       phase;

    // phase flips on the latch edge after TURBO_FRAMES polls have been served in the current phase
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            turbo_cnt <= '0;
            phase     <= 1'b0;
        end else if (l_rise) begin
            phase     <= (turbo_cnt == 8'(TURBO_FRAMES)) ? ~phase : phase;
            turbo_cnt <= (turbo_cnt == 8'(TURBO_FRAMES)) ? 8'd1 : turbo_cnt + 8'd1;
        end

    assign eb = {buttons[7:2], buttons[1] | (turbo_b & phase), buttons[0] | (turbo_a & phase)};
`else
    logic unused_turbo;
    assign unused_turbo = turbo_a | turbo_b;
    assign eb = buttons;
`endif

    // latch loads transparently; pulse edges shift with released (0) fill; counters saturate/wrap
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            shift      <= 8'h00;
            nes_data   <= 1'b1;
            bit_count  <= 4'd8;
            frame_done <= 1'b0;
            poll_count <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (l_rise) poll_count <= poll_count + 8'd1;
            if (l_sync) begin
                shift     <= eb;
                bit_count <= 4'd0;
                nes_data  <= ~eb[0];
            end else if (p_rise) begin
                shift      <= {1'b0, shift[7:1]};
                nes_data   <= ~shift[1];
                bit_count  <= (bit_count == 4'd8) ? 4'd8 : bit_count + 4'd1;
                frame_done <= bit_count == 4'd7;
            end
        end
endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

- Emulates the controller end of the NES serial pad protocol: a 4021-style parallel-in/serial-out responder driven by an external latch/pulse initiator.
- Captures an 8-bit button vector while latch is high and shifts it out on `nes_data`, one bit per pulse rising edge.
- Used in the Tetris design for loopback against the input controller and for driving bench stimulus on the `nes_in` wire, with no physical pad.

## Interface
Parameters:
- `TURBO_FRAMES`, 2: latch rising edges per turbo phase toggle (1..255); only used with `TURBO_EN`.

Ports:
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `buttons` in 8: pressed = 1; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- `turbo_a` in 1: turbo A request (with `TURBO_EN` only).
- `turbo_b` in 1: turbo B request (with `TURBO_EN` only).
- `nes_latch` in 1: latch from initiator; asynchronous to `clk`, active-high.
- `nes_pulse` in 1: shift clock from initiator; asynchronous to `clk`, active-high.
- `nes_data` out 1: serial data; active-low (pressed = 0).
- `bit_count` out 4: bits shifted since last latch, 0..8, saturating.
- `frame_done` out 1: one-cycle strobe when the 8th bit has been shifted.
- `poll_count` out 8: latch rising-edge count, wraps 255 -> 0.

## Operation
- Reset values:
  - Sync flops and edge-history flops 0.
  - `shift` 8'h00.
  - `nes_data` 1.
  - `bit_count` 8.
  - `frame_done` 0.
  - `poll_count` 0.
  - Turbo phase 0, turbo edge counter 0.
- `nes_latch` and `nes_pulse` each pass through a 2-flop synchronizer plus a history flop. `L` and `P` are the synchronized levels; `P_rise` = P & ~P_prev.
- Effective buttons `eb` = `buttons` (plus turbo masking when enabled).
- Per-cycle priority, evaluated at the clock edge:
  - LOAD (`L` = 1): `shift` <= `eb`, `bit_count` <= 0, `nes_data` <= ~`eb[0]`. Repeats every cycle while `L` = 1, so the value is transparent to button changes until latch falls. `P_rise` is ignored while `L` = 1.
  - SHIFT (`L` = 0 and `P_rise`):
    - `shift` <= {1'b0, `shift[7:1]`}.
    - `nes_data` <= ~`shift[1]`.
    - `bit_count` <= min(`bit_count` + 1, 8).
  - IDLE: hold all state.
- Fill is 0 (released), so after 8 shifts `nes_data` stays 1 for any further pulses.
- `frame_done` = 1 for exactly the cycle following a SHIFT that moved `bit_count` from 7 to 8. Otherwise 0.
- `poll_count` increments on each `L` rising edge.
- Latch falling edge: no action. The last LOAD value is frozen, and `nes_data` already shows A.
- A latch arriving mid-frame aborts the frame: `bit_count` goes to 0 and there is no `frame_done`.
- Asynchronous reset mid-frame forces the reset values immediately. The first post-reset LOAD occurs on the first synchronized latch.

## Timing
- Pin transition first sampled at edge k: synchronized at k+1, acted on at k+2.
- `nes_data` changes registered at edge k+2, i.e. latency 2–3 clk periods from pin to pin.
- Input high/low widths of at least 3 clk periods are required. Shorter pulses may be missed, and that is not an error condition.
- `nes_data` is a flop output, glitch-free, with no combinational path from any input.
- `bit_count` and `poll_count` update on the same edge as the action that causes them.

## Configuration
- `NES_PAD_TURBO_EN` defined:
  - A turbo phase flop toggles every `TURBO_FRAMES` latch rising edges.
  - `eb[0]` = `buttons[0]` | (`turbo_a` & phase); `eb[1]` = `buttons[1]` | (`turbo_b` & phase).
  - The counter and phase reset to 0.
- `NES_PAD_TURBO_EN` undefined:
  - `turbo_a`/`turbo_b` are ignored and `eb` = `buttons`.
  - No turbo counter or phase logic is synthesized.

## Test plan
- Reset low, then high, with no latch activity -> `nes_data` = 1, `bit_count` = 8, `poll_count` = 0, `frame_done` never asserted.
- `buttons` = 8'b1000_0101; latch high 10 cycles, then low; 8 pulses (4 high/4 low) -> `nes_data` sequence 0,1,0,1,1,1,1,0 (A first). `frame_done` = 1 once after the 8th pulse; `bit_count` = 8.
- After that frame, 4 extra pulses -> `nes_data` stays 1, `bit_count` stays 8, no `frame_done`.
- Pulses while latch is high, then change `buttons` to 8'h01 before latch falls -> no shifts; first bit reflects 8'h01 (`nes_data` = 0), `bit_count` = 0.
- Latch after 3 pulses (mid-frame), then reset low mid-frame -> new LOAD with `bit_count` = 0 and no `frame_done`; reset immediately forces `nes_data` = 1, `bit_count` = 8, `poll_count` = 0.
- With `NES_PAD_TURBO_EN`, `TURBO_FRAMES` = 2, `turbo_a` = 1, `buttons` = 0 -> bit A reads released, released, pressed, pressed, released over 5 consecutive polls; `poll_count` = 5.
